// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small input FIFO; frame format and bit period are
// latched per frame, so queued bytes go out back-to-back with no idle gap.
module uart_tx_fifo_cfg #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic [1:0]           i_cfg_bits,
    input  logic [1:0]           i_cfg_parity,
    input  logic                 i_cfg_stop2,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 s_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_fifo_count,
    output logic [2:0]           dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0] count;

    state_t               state;
    logic [7:0]           shifter;
    logic [DIV_WIDTH-1:0] div_m1, cyc_cnt;
    logic [2:0]           last_bit, bit_cnt;
    logic                 par_en, par_bit, stop2_q, stop_cnt;

    logic                 push, pop, have_data, bit_end, frame_end;
    logic [7:0]           head, cfg_mask;
    logic [DIV_WIDTH-1:0] lat_div_m1;

    // Handshake: s_data is taken on every edge where s_valid && s_ready are
    // both high; s_ready depends only on the registered count, never on s_valid.
    assign s_ready      = (count < CNT_WIDTH'(FIFO_DEPTH));
    assign push         = s_valid && s_ready;
    assign have_data    = (count != '0);
    assign head         = mem[rd_ptr];
    assign bit_end      = (cyc_cnt == div_m1);
    assign frame_end    = (state == STOP) && bit_end && (!stop2_q || stop_cnt);
    assign pop          = have_data && ((state == IDLE) || frame_end);

    assign cfg_mask     = 8'hFF >> (2'd3 - i_cfg_bits);
    assign lat_div_m1   = (i_div == '0) ? '0 : i_div - DIV_WIDTH'(1);

    assign o_busy       = (state != IDLE);
    assign o_fifo_count = count;
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CNT_WIDTH'(1);
            else if (pop && !push) count <= count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            o_tx     <= 1'b1;
            o_done   <= 1'b0;
            shifter  <= '0;
            div_m1   <= '0;
            cyc_cnt  <= '0;
            last_bit <= '0;
            bit_cnt  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (have_data) begin
                        state <= START;
                        o_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= DATA;
                        o_tx    <= shifter[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == last_bit) begin
                            state <= par_en ? PARITY : STOP;
                            o_tx  <= par_en ? par_bit : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shifter <= shifter >> 1;
                            o_tx    <= shifter[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= STOP;
                        o_tx    <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (stop2_q && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                            state  <= have_data ? START : IDLE;
                            o_tx   <= !have_data;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    o_tx  <= 1'b1;
                end
            endcase

            // Frame start: take the head byte and freeze the format until the next frame.
            if (pop) begin
                shifter  <= head;
                div_m1   <= lat_div_m1;
                last_bit <= {1'b1, i_cfg_bits};
                par_en   <= i_cfg_parity[1];
                par_bit  <= (^(head & cfg_mask)) ^ i_cfg_parity[0];
                stop2_q  <= i_cfg_stop2;
                cyc_cnt  <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: a per-clock line-level model built from the frame
// rules is compared against the DUT outputs every cycle.
module tb_uart_tx_fifo_cfg;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_div = 16'd4;
    logic [1:0]    i_cfg_bits = 2'd3;
    logic [1:0]    i_cfg_parity = 2'd0;
    logic          i_cfg_stop2 = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready, o_tx, o_busy, o_done;
    logic [CW-1:0] o_fifo_count;
    logic [2:0]    dbg_state;

    uart_tx_fifo_cfg #(.DIV_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_div(i_div), .i_cfg_bits(i_cfg_bits),
        .i_cfg_parity(i_cfg_parity), .i_cfg_stop2(i_cfg_stop2),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .o_tx(o_tx),
        .o_busy(o_busy), .o_done(o_done), .o_fifo_count(o_fifo_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: exp_q holds the line level for every remaining clock of the current frame.
    logic [0:0] exp_q[$];
    logic [7:0] mdl_fifo[$];
    logic       mdl_done = 1'b0;

    int  test_cnt = 0, err_cnt = 0;
    int  done_seen = 0, busy_cyc = 0, bad_gap = 0, cyc_no = 0, last_done = 0;
    bit  chk_en = 1'b0, gap_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void emit(logic b, int n);
        for (int k = 0; k < n; k++) exp_q.push_back(b);
    endfunction

    function automatic void add_frame(logic [7:0] d, logic [DW-1:0] dv, logic [1:0] bits,
                                      logic [1:0] par, logic s2);
        int   eff = (dv < 2) ? 1 : int'(dv);
        int   n   = 5 + int'(bits);
        logic p   = par[0];
        emit(1'b0, eff);
        for (int i = 0; i < n; i++) begin
            emit(d[i], eff);
            p = p ^ d[i];
        end
        if (par[1]) emit(p, eff);
        emit(1'b1, s2 ? 2 * eff : eff);
    endfunction

    always @(posedge clk) begin : model_blk
        bit acc, ending;
        acc = s_valid && (mdl_fifo.size() < DEPTH);
        if (rst) begin
            exp_q.delete();
            mdl_fifo.delete();
            mdl_done = 1'b0;
        end else begin
            ending = (exp_q.size() == 1);
            if (exp_q.size() > 0) exp_q.delete(0);
            if (exp_q.size() == 0 && mdl_fifo.size() > 0)
                add_frame(mdl_fifo.pop_front(), i_div, i_cfg_bits, i_cfg_parity, i_cfg_stop2);
            if (acc) mdl_fifo.push_back(s_data);
            mdl_done = ending;
        end
    end

    always @(negedge clk) begin
        cyc_no++;
        if (chk_en) begin
            check("tx",    o_tx,         (exp_q.size() > 0) ? exp_q[0] : 1'b1);
            check("busy",  o_busy,       exp_q.size() != 0);
            check("done",  o_done,       mdl_done);
            check("count", o_fifo_count, mdl_fifo.size());
            check("ready", s_ready,      mdl_fifo.size() < DEPTH);
            if (o_busy) busy_cyc++;
            if (o_done) begin
                done_seen++;
                if (gap_en && last_done != 0 && (cyc_no - last_done) != 20) bad_gap++;
                last_done = cyc_no;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(int dv, int bits, int par, bit s2);
        i_div        = DW'(dv);
        i_cfg_bits   = 2'(bits);
        i_cfg_parity = 2'(par);
        i_cfg_stop2  = s2;
    endtask

    // Holds s_valid with the byte until an edge accepts it; leaves s_valid high.
    task automatic push_byte(logic [7:0] d);
        bit acc = 1'b0;
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 2000);
        check("push_timeout", acc, 1);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mdl_fifo.size() != 0 || o_busy) && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout", n < budget, 1);
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        tick(1);
        chk_en = 1'b1;
        check("rst_tx", o_tx, 1);
        check("rst_ready", s_ready, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_count", o_fifo_count, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // 8N1 at div 4
        set_cfg(4, 3, 0, 0);
        busy_cyc = 0; done_seen = 0;
        push_byte(8'h55); s_valid = 1'b0;
        wait_idle(500);
        check("busy_len_8n1", busy_cyc, 40);
        check("done_cnt_8n1", done_seen, 1);

        // 7E1 / 7O1 at div 3, bit 7 ignored
        set_cfg(3, 2, 2, 0);
        busy_cyc = 0;
        push_byte(8'h41); s_valid = 1'b0;
        wait_idle(500);
        check("busy_len_7e1", busy_cyc, 30);
        set_cfg(3, 2, 3, 0);
        push_byte(8'h41); s_valid = 1'b0;
        wait_idle(500);
        set_cfg(3, 2, 2, 0);
        push_byte(8'hC1); s_valid = 1'b0;
        wait_idle(500);

        // 8O2 at div 2
        set_cfg(2, 3, 3, 1);
        busy_cyc = 0;
        push_byte(8'hFF); s_valid = 1'b0;
        wait_idle(500);
        check("busy_len_8o2", busy_cyc, 24);

        // Six bytes back-to-back, FIFO fills and drains gaplessly
        set_cfg(2, 3, 0, 0);
        busy_cyc = 0; done_seen = 0; bad_gap = 0; last_done = 0; gap_en = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'hA0 + 8'(i));
        s_valid = 1'b0;
        wait_idle(1000);
        gap_en = 1'b0;
        check("b2b_done_cnt", done_seen, 6);
        check("b2b_busy_len", busy_cyc, 120);
        check("b2b_done_gap", bad_gap, 0);

        // Config change mid-frame applies only to the next frame
        set_cfg(4, 3, 0, 0);
        busy_cyc = 0;
        push_byte(8'hA5); s_valid = 1'b0;
        tick(6);
        push_byte(8'h3C); s_valid = 1'b0;
        set_cfg(8, 0, 0, 0);
        wait_idle(1000);
        check("busy_len_cfgchg", busy_cyc, 96);

        // Reset during DATA with three bytes queued
        set_cfg(4, 3, 0, 0);
        for (int i = 0; i < 4; i++) push_byte(8'h11 * 8'(i + 1));
        s_valid = 1'b0;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_tx", o_tx, 1);
        check("midrst_busy", o_busy, 0);
        check("midrst_count", o_fifo_count, 0);
        check("midrst_ready", s_ready, 1);
        check("midrst_done", o_done, 0);
        push_byte(8'h5A); s_valid = 1'b0;
        wait_idle(500);

        // Random traffic, formats, divisors and occasional resets
        for (int c = 0; c < 4000; c++) begin
            s_valid = ($urandom_range(0, 2) == 0);
            s_data  = 8'($urandom);
            if ($urandom_range(0, 39) == 0)
                set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        wait_idle(5000);

        $display("[TB] %0d tests run, %0d failed", test_cnt, err_cnt);
        $finish;
    end

endmodule
